shift_sequencer: RTL and testbench

Controller that performs a multi-bit logical shift by sequencing an external single-step left/right shift SFR (load, shift-left-by-1, shift-right-by-1 controls).
- Accepts a request of data, direction and amount; loads the SFR, issues one shift step per cycle, captures the result and pulses done.
- Sits between the execute-stage shifter request and the shift SFR, which has no reset and no count logic of its own.

---
 rtl/shift_sequencer_pkg.sv | 14 +
 rtl/shift_sequencer_if.sv | 24 ++
 rtl/shift_step_counter.sv | 33 +++
 rtl/shift_sequencer.sv | 126 ++++++++++++
 tb/tb_shift_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared state and direction encodings for the shift sequencer
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_CAPT  = 2'd3
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/response interface between shifter requester and sequencer
interface shift_sequencer_if #(
  parameter int SIZE  = 32,
  parameter int AMT_W = 6
);
  logic             start;
  logic             dir;
  logic [AMT_W-1:0] amt;
  logic [SIZE-1:0]  din;
  logic             abort;
  logic             busy;
  logic             done;
  logic [SIZE-1:0]  dout;

  modport master (
    output start, dir, amt, din, abort,
    input  busy, done, dout
  );

  modport slave (
    input  start, dir, amt, din, abort,
    output busy, done, dout
  );
endinterface

// File: rtl/shift_step_counter.sv
// rtl/shift_step_counter.sv - loadable step down-counter, clamps the load value to SIZE
module shift_step_counter #(
  parameter int SIZE  = 32,
  parameter int AMT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [AMT_W-1:0] i_amt,
  output logic             o_zero,
  output logic             o_one
);

  localparam logic [AMT_W-1:0] SIZE_C = AMT_W'(SIZE);

  logic [AMT_W-1:0] r_cnt;

  // Amounts past the data width saturate so at most SIZE steps are ever issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= (i_amt >= SIZE_C) ? SIZE_C : i_amt;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - AMT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);
  assign o_one  = (r_cnt == AMT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - sequences a single-step shift SFR to perform a multi-bit logical shift
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int AMT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  shift_sequencer_if.slave    bus,
  output logic                o_sfr_ld,
  output logic                o_sfr_left,
  output logic                o_sfr_right,
  output logic [SIZE-1:0]     o_sfr_d,
  input  logic [SIZE-1:0]     i_sfr_q
);

  state_t          r_state;
  logic            r_dir;
  logic            r_busy;
  logic            r_done;
  logic [SIZE-1:0] r_dout;
  logic [SIZE-1:0] r_sfr_d;
  logic            r_sfr_ld;
  logic            r_sfr_left;
  logic            r_sfr_right;

  logic w_load;
  logic w_dec;
  logic w_zero;
  logic w_one;

  assign w_load = (r_state == ST_IDLE) && bus.start && !bus.abort;
  assign w_dec  = (r_state == ST_SHIFT);

  shift_step_counter #(
    .SIZE  (SIZE),
    .AMT_W (AMT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_dec  (w_dec),
    .i_amt  (bus.amt),
    .o_zero (w_zero),
    .o_one  (w_one)
  );

  // SFR enables are registered alongside the state so they track it exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_dir       <= DIR_LEFT;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dout      <= '0;
      r_sfr_d     <= '0;
      r_sfr_ld    <= 1'b0;
      r_sfr_left  <= 1'b0;
      r_sfr_right <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_dir    <= bus.dir;
            r_sfr_d  <= bus.din;
            r_sfr_ld <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_sfr_ld <= 1'b0;
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_zero) begin
            r_state <= ST_CAPT;
          end else begin
            r_sfr_left  <= (r_dir == DIR_LEFT);
            r_sfr_right <= (r_dir == DIR_RIGHT);
            r_state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bus.abort) begin
            r_sfr_left  <= 1'b0;
            r_sfr_right <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_one) begin
            r_sfr_left  <= 1'b0;
            r_sfr_right <= 1'b0;
            r_state     <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          // abort wins over the capture: dout keeps the previous result
          if (!bus.abort) begin
            r_dout <= i_sfr_q;
            r_done <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_sfr_ld    <= 1'b0;
          r_sfr_left  <= 1'b0;
          r_sfr_right <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.dout    = r_dout;
  assign o_sfr_ld    = r_sfr_ld;
  assign o_sfr_left  = r_sfr_left;
  assign o_sfr_right = r_sfr_right;
  assign o_sfr_d     = r_sfr_d;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer with an attached SFR model
module tb_shift_sequencer;

  localparam int SIZE  = 32;
  localparam int AMT_W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_sequencer_if #(.SIZE(SIZE), .AMT_W(AMT_W)) bus ();

  logic            sfr_ld;
  logic            sfr_left;
  logic            sfr_right;
  logic [SIZE-1:0] sfr_d;
  logic [SIZE-1:0] sfr_q;

  shift_sequencer #(.SIZE(SIZE), .AMT_W(AMT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_sfr_ld    (sfr_ld),
    .o_sfr_left  (sfr_left),
    .o_sfr_right (sfr_right),
    .o_sfr_d     (sfr_d),
    .i_sfr_q     (sfr_q)
  );

  always @(posedge clk) begin
    if (sfr_ld)         sfr_q <= sfr_d;
    else if (sfr_left)  sfr_q <= sfr_q << 1;
    else if (sfr_right) sfr_q <= sfr_q >> 1;
  end

  int              cyc = 0;
  int              n_left = 0;
  int              n_right = 0;
  int              n_illegal = 0;
  int              done_cyc[$];
  logic [SIZE-1:0] done_val[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cyc.push_back(cyc);
      done_val.push_back(bus.dout);
    end
    if (sfr_left === 1'b1)  n_left++;
    if (sfr_right === 1'b1) n_right++;
    if ((sfr_left && sfr_right) || (sfr_ld && (sfr_left || sfr_right))) n_illegal++;
  end

  int              total = 0;
  int              bad = 0;
  logic [SIZE-1:0] last_dout = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int steps_of(input logic [AMT_W-1:0] a);
    return (int'(a) >= SIZE) ? SIZE : int'(a);
  endfunction

  function automatic logic [SIZE-1:0] ref_shift(input logic [SIZE-1:0] d, input logic dr,
                                                 input logic [AMT_W-1:0] a);
    int k = steps_of(a);
    if (k >= SIZE) return '0;
    return dr ? (d >> k) : (d << k);
  endfunction

  task automatic start_op(input logic [SIZE-1:0] d, input logic dr, input logic [AMT_W-1:0] a,
                          output int c0);
    n_left  = 0;
    n_right = 0;
    bus.start = 1'b1;
    bus.din   = d;
    bus.dir   = dr;
    bus.amt   = a;
    c0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.din   = $urandom;
    bus.dir   = ~dr;
    bus.amt   = AMT_W'($urandom);
    check("busy_after_start", {63'd0, bus.busy}, 64'd1);
  endtask

  task automatic wait_until(input int target);
    for (int i = 0; i < 400 && cyc < target; i++) @(negedge clk);
    check("wait_bound", {63'd0, cyc >= target}, 64'd1);
  endtask

  task automatic expect_op(input string tag, input int c0, input logic [SIZE-1:0] d,
                           input logic dr, input logic [AMT_W-1:0] a);
    int k = steps_of(a);
    logic [SIZE-1:0] exp = ref_shift(d, dr, a);
    wait_until(c0 + k + 4);
    check({tag, "_ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) begin
      check({tag, "_lat"}, done_cyc[0] - c0, k + 2);
      check({tag, "_dout"}, done_val[0], exp);
    end
    check({tag, "_steps"}, dr ? n_right : n_left, k);
    check({tag, "_wrongdir"}, dr ? n_left : n_right, 0);
    last_dout = exp;
    done_cyc.delete();
    done_val.delete();
  endtask

  int              c0;
  int              c1;
  logic [SIZE-1:0] rd;
  logic            rdir;
  logic [AMT_W-1:0] ra;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    bus.amt   = '0;
    bus.din   = '0;
    bus.abort = 1'b0;
    #3;
    check("rst_busy",  {63'd0, bus.busy},  64'd0);
    check("rst_done",  {63'd0, bus.done},  64'd0);
    check("rst_dout",  bus.dout, 64'd0);
    check("rst_ld",    {61'd0, sfr_ld, sfr_left, sfr_right}, 64'd0);
    check("rst_sfr_d", sfr_d, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", {63'd0, bus.busy}, 64'd0);

    start_op(32'h0000_00F1, 1'b0, 6'd4, c0);
    expect_op("left4", c0, 32'h0000_00F1, 1'b0, 6'd4);

    start_op(32'h8000_0001, 1'b1, 6'd31, c0);
    expect_op("right31", c0, 32'h8000_0001, 1'b1, 6'd31);

    start_op(32'hA5C3_5A3C, 1'b1, 6'd0, c0);
    expect_op("amt0", c0, 32'hA5C3_5A3C, 1'b1, 6'd0);

    start_op(32'hFFFF_FFFF, 1'b0, 6'd40, c0);
    expect_op("over40", c0, 32'hFFFF_FFFF, 1'b0, 6'd40);

    start_op(32'h1234_5678, 1'b0, 6'd5, c0);
    wait_until(c0 + 2);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_en", {61'd0, sfr_ld, sfr_left, sfr_right}, 64'd0);
    wait_until(c0 + 12);
    check("abort_ndone", done_cyc.size(), 0);
    check("abort_dout", bus.dout, last_dout);
    done_cyc.delete();
    done_val.delete();

    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.din   = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("idle_abort_busy", {63'd0, bus.busy}, 64'd0);
    repeat (4) @(negedge clk);
    check("idle_abort_ndone", done_cyc.size(), 0);

    start_op(32'h0F0F_0001, 1'b0, 6'd6, c0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.din   = 32'hFFFF_0000;
    bus.dir   = 1'b1;
    bus.amt   = 6'd2;
    @(negedge clk);
    bus.start = 1'b0;
    expect_op("busy_start", c0, 32'h0F0F_0001, 1'b0, 6'd6);

    start_op(32'h0000_0003, 1'b0, 6'd1, c0);
    wait_until(c0 + 3);
    check("b2b_done1", {63'd0, bus.done}, 64'd1);
    rd = 32'hC000_0000;
    bus.start = 1'b1;
    bus.din   = rd;
    bus.dir   = 1'b1;
    bus.amt   = 6'd7;
    c1 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(c1 + 11);
    check("b2b_ndone", done_cyc.size(), 2);
    if (done_cyc.size() == 2) begin
      check("b2b_lat1",  done_cyc[0] - c0, 3);
      check("b2b_dout1", done_val[0], ref_shift(32'h0000_0003, 1'b0, 6'd1));
      check("b2b_lat2",  done_cyc[1] - c1, 9);
      check("b2b_dout2", done_val[1], ref_shift(rd, 1'b1, 6'd7));
    end
    last_dout = ref_shift(rd, 1'b1, 6'd7);
    done_cyc.delete();
    done_val.delete();

    for (int i = 0; i < 10; i++) begin
      rd   = $urandom;
      rdir = 1'($urandom_range(0, 1));
      ra   = AMT_W'($urandom_range(0, 63));
      start_op(rd, rdir, ra, c0);
      expect_op("rand", c0, rd, rdir, ra);
    end

    check("illegal_enables", n_illegal, 0);

    start_op(32'h5555_AAAA, 1'b1, 6'd10, c0);
    wait_until(c0 + 4);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_en", {61'd0, sfr_ld, sfr_left, sfr_right}, 64'd0);
    check("midrst_dout", bus.dout, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("midrst_ndone", done_cyc.size(), 0);
    check("midrst_dout_hold", bus.dout, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
